// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int NUM_TICKS      = 16;
    localparam int START_MID_TICK = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; RESET_VALUE sets the flop reset level.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_r;
    logic sync_r;

    // Metastability-settling flop pair
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            meta_r <= RESET_VALUE;
            sync_r <= RESET_VALUE;
        end else begin
            meta_r <= i_d;
            sync_r <= meta_r;
        end
    end

    assign o_q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled: recovers LSB-first words from i_rx and strobes o_rx_done per frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_TICKS = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_rx,
    input  logic                 i_tick,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_error
);

    localparam int S_W = (STOP_TICKS > NUM_TICKS) ? $clog2(STOP_TICKS) : 4;
    localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [S_W-1:0] S_ZERO = S_W'(32'd0);
    localparam logic [S_W-1:0] S_ONE  = S_W'(32'd1);
    localparam logic [S_W-1:0] S_MID  = S_W'(START_MID_TICK);
    localparam logic [S_W-1:0] S_BIT  = S_W'(NUM_TICKS - 1);
    localparam logic [S_W-1:0] S_STOP = S_W'(STOP_TICKS - 1);
    localparam logic [N_W-1:0] N_ZERO = N_W'(32'd0);
    localparam logic [N_W-1:0] N_ONE  = N_W'(32'd1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state_r, state_s;
    logic [S_W-1:0]       s_cnt_r, s_cnt_s;
    logic [N_W-1:0]       n_cnt_r, n_cnt_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic [DATA_BITS-1:0] data_r, data_s;
    logic                 done_r, done_s;
    logic                 ferr_r, ferr_s;

    sync_2ff #(
        .RESET_VALUE(1'b1)
    ) u_rx_sync (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_d    (i_rx),
        .o_q    (rx_s)
    );

    // Next-state and output logic; done defaults low so it can only pulse for one clock
    always_comb begin
        state_s = state_r;
        s_cnt_s = s_cnt_r;
        n_cnt_s = n_cnt_r;
        shift_s = shift_r;
        data_s  = data_r;
        ferr_s  = ferr_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rx_s) begin
                    state_s = START;
                    s_cnt_s = S_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (i_tick) begin
                    if (s_cnt_r == S_MID) begin
                        s_cnt_s = S_ZERO;
                        if (!rx_s) begin
                            state_s = DATA;
                            n_cnt_s = N_ZERO;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                        s_cnt_s = s_cnt_r + S_ONE;
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                // START already consumed half a bit, so each full bit count lands mid-bit
                if (i_tick) begin
                    if (s_cnt_r == S_BIT) begin
                        s_cnt_s = S_ZERO;
                        shift_s = {rx_s, shift_r[DATA_BITS-1:1]};
                        if (n_cnt_r == N_LAST) begin
                            state_s = STOP;
                        end else begin
                            n_cnt_s = n_cnt_r + N_ONE;
                        end
                    end else begin
                        s_cnt_s = s_cnt_r + S_ONE;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (s_cnt_r == S_STOP) begin
                        data_s  = shift_r;
                        ferr_s  = ~rx_s;
                        done_s  = 1'b1;
                        state_s = IDLE;
                        s_cnt_s = S_ZERO;
                    end else begin
                        s_cnt_s = s_cnt_r + S_ONE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
                s_cnt_s = S_ZERO;
                n_cnt_s = N_ZERO;
            end
        endcase
    end

    // State, counters, shift register and registered outputs
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= IDLE;
            s_cnt_r <= S_ZERO;
            n_cnt_r <= N_ZERO;
            shift_r <= {DATA_BITS{1'b0}};
            data_r  <= {DATA_BITS{1'b0}};
            done_r  <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            s_cnt_r <= s_cnt_s;
            n_cnt_r <= n_cnt_s;
            shift_r <= shift_s;
            data_r  <= data_s;
            done_r  <= done_s;
            ferr_r  <= ferr_s;
        end
    end

    assign o_data        = data_r;
    assign o_rx_done     = done_r;
    assign o_frame_error = ferr_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame-level expectation queue checked every cycle plus literal spot checks.
module tb_uart_rx;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_rx    = 1'b1;
    logic       i_tick  = 1'b0;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_error;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    bit tick_all    = 1'b0;

    logic [8:0] exp_q[$];
    logic [7:0] exp_data = 8'h00;
    logic       exp_err  = 1'b0;
    logic       prev_done = 1'b0;

    uart_rx #(
        .DATA_BITS (8),
        .STOP_TICKS(16)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_rx         (i_rx),
        .i_tick       (i_tick),
        .o_data       (o_data),
        .o_rx_done    (o_rx_done),
        .o_frame_error(o_frame_error)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Tick source: one clock in four, or every clock when tick_all is set
    initial begin
        int tcnt;
        tcnt = 0;
        forever begin
            @(negedge i_clock);
            tcnt   = (tcnt + 1) % 4;
            i_tick = tick_all || (tcnt == 0);
        end
    end

    // Per-cycle compare against the frame-level expectation model
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge i_clock);
            if (!i_reset) begin
                exp_data  = 8'h00;
                exp_err   = 1'b0;
                prev_done = 1'b0;
                check("reset_done", {31'd0, o_rx_done}, 32'd0);
            end else begin
                if (o_rx_done) begin
                    done_cnt++;
                    check("done_width", {31'd0, prev_done}, 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e        = exp_q.pop_front();
                        exp_data = e[7:0];
                        exp_err  = e[8];
                    end
                end
                prev_done = o_rx_done;
            end
            check("data", {24'd0, o_data}, {24'd0, exp_data});
            check("ferr", {31'd0, o_frame_error}, {31'd0, exp_err});
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge i_clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int bit_clks, input int stop_clks);
        exp_q.push_back({~stop_v, d});
        @(negedge i_clock);
        i_rx = 1'b0;
        clks(bit_clks);
        for (int b = 0; b < 8; b++) begin
            i_rx = d[b];
            clks(bit_clks);
        end
        i_rx = stop_v;
        clks(stop_clks);
        i_rx = 1'b1;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge i_clock);
        check(nm, exp_q.size(), 32'd0);
        exp_q.delete();
        clks(8);
    endtask

    initial begin
        int base;
        clks(3);
        check("rst_data", {24'd0, o_data}, 32'h00);
        check("rst_err", {31'd0, o_frame_error}, 32'd0);
        @(negedge i_clock);
        i_reset = 1'b1;
        clks(20);

        // 1: good 0xA5
        base = done_cnt;
        send_frame(8'hA5, 1'b1, 64, 64);
        drain("t1_drain");
        check("t1_pulses", done_cnt - base, 32'd1);
        check("t1_data", {24'd0, o_data}, 32'hA5);
        check("t1_err", {31'd0, o_frame_error}, 32'd0);

        // 2: 3-tick glitch rejected, then 0x3C
        base = done_cnt;
        @(negedge i_clock);
        i_rx = 1'b0;
        clks(12);
        i_rx = 1'b1;
        clks(200);
        check("t2_glitch", done_cnt - base, 32'd0);
        send_frame(8'h3C, 1'b1, 64, 64);
        drain("t2_drain");
        check("t2_data", {24'd0, o_data}, 32'h3C);

        // 3: 0x81 with low stop bit, then good 0x7E clears error
        send_frame(8'h81, 1'b0, 64, 48);
        drain("t3_drain");
        check("t3_data", {24'd0, o_data}, 32'h81);
        check("t3_err", {31'd0, o_frame_error}, 32'd1);
        clks(200);
        send_frame(8'h7E, 1'b1, 64, 64);
        drain("t3b_drain");
        check("t3b_data", {24'd0, o_data}, 32'h7E);
        check("t3b_err", {31'd0, o_frame_error}, 32'd0);

        // 4: back-to-back frames with no idle gap
        base = done_cnt;
        send_frame(8'h00, 1'b1, 64, 64);
        send_frame(8'hFF, 1'b1, 64, 64);
        send_frame(8'h55, 1'b1, 64, 64);
        drain("t4_drain");
        check("t4_pulses", done_cnt - base, 32'd3);
        check("t4_data", {24'd0, o_data}, 32'h55);

        // 5: reset during data bit 4 of 0xC3, then 0x5A
        @(negedge i_clock);
        i_rx = 1'b0;
        clks(64);
        for (int b = 0; b < 4; b++) begin
            i_rx = (8'hC3 >> b) & 8'h01;
            clks(64);
        end
        i_rx = 1'b0;
        clks(32);
        #2 i_reset = 1'b0;
        #1;
        check("t5_async_data", {24'd0, o_data}, 32'h00);
        check("t5_async_done", {31'd0, o_rx_done}, 32'd0);
        check("t5_async_err", {31'd0, o_frame_error}, 32'd0);
        i_rx = 1'b1;
        clks(5);
        i_reset = 1'b1;
        clks(100);
        send_frame(8'h5A, 1'b1, 64, 64);
        drain("t5_drain");
        check("t5_data", {24'd0, o_data}, 32'h5A);

        // 6: tick held high, 16 clocks per bit
        base     = done_cnt;
        tick_all = 1'b1;
        clks(2);
        send_frame(8'h96, 1'b1, 16, 16);
        drain("t6_drain");
        clks(40);
        tick_all = 1'b0;
        check("t6_pulses", done_cnt - base, 32'd1);
        check("t6_data", {24'd0, o_data}, 32'h96);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
